// File: rtl/cnt_scheduler.sv
// cnt_scheduler: round-robin arbiter that lends one internal interval counter
// to NUM_REQ requesters. Winner's terminal count is latched at grant; the
// count runs (or is held) until it reaches the terminal, then a one-cycle done
// pulse goes to the owner and the scheduler returns to IDLE for one cycle.
//
// Handshake: i_req is a level request. The grant is committed once issued;
// dropping i_req during RUN does not cancel it. o_done is the only completion
// indication, and i_abort ends an interval without a done.
module cnt_scheduler #(
  parameter int BIT_WIDTH = 8,
  parameter int NUM_REQ   = 4,
  parameter int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                         I_CLK,
  input  logic                         I_RSTN,
  input  logic [NUM_REQ-1:0]           i_req,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] i_max_cnt,
  input  logic                         i_hold,
  input  logic                         i_abort,
  output logic [NUM_REQ-1:0]           o_grant,
  output logic [IDX_W-1:0]             o_owner,
  output logic                         o_busy,
  output logic [BIT_WIDTH-1:0]         o_cnt,
  output logic [NUM_REQ-1:0]           o_done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     ptr_q,   ptr_d;
  logic [BIT_WIDTH-1:0] term_q,  term_d;
  logic [BIT_WIDTH-1:0] cnt_q,   cnt_d;

  logic                 win_vld;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W:0]       arb_sum;
  logic [IDX_W-1:0]     arb_cand;
  logic [IDX_W-1:0]     owner_inc;
  logic                 term_hit;

  // Round-robin search: first set request at or after the pointer, wrapping.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    arb_sum  = '0;
    arb_cand = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      arb_sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (arb_sum >= (IDX_W+1)'(NUM_REQ)) begin
        arb_sum = arb_sum - (IDX_W+1)'(NUM_REQ);
      end
      arb_cand = arb_sum[IDX_W-1:0];
      if (!win_vld && i_req[arb_cand]) begin
        win_vld = 1'b1;
        win_idx = arb_cand;
      end
    end
  end

  // Owner index plus one, wrapping at NUM_REQ (need not be a power of two).
  always_comb begin
    owner_inc = (owner_q == IDX_W'(NUM_REQ-1)) ? '0 : owner_q + IDX_W'(1);
  end

  // Interval completes when the count sits on the terminal and is not held.
  always_comb begin
    term_hit = (cnt_q == term_q) && !i_hold;
  end

  // State register and datapath registers.
  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      term_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      term_q  <= term_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: arbitrate in IDLE; abort > completion > count > hold in RUN.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    term_d  = term_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d = ST_RUN;
          owner_d = win_idx;
          term_d  = i_max_cnt[win_idx*BIT_WIDTH +: BIT_WIDTH];
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (i_abort || term_hit) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          ptr_d   = owner_inc;
        end else if (!i_hold) begin
          cnt_d = cnt_q + BIT_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode registered state; only i_hold/i_abort reach o_done directly.
  always_comb begin
    o_grant = '0;
    o_done  = '0;
    o_owner = '0;
    o_busy  = 1'b0;
    o_cnt   = cnt_q;
    if (state_q == ST_RUN) begin
      o_busy           = 1'b1;
      o_owner          = owner_q;
      o_grant[owner_q] = 1'b1;
      if (term_hit && !i_abort) begin
        o_done[owner_q] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cnt_scheduler.sv
// Bench for cnt_scheduler: directed scenarios plus randomized traffic, all
// compared cycle by cycle against a transaction-level reference model.
module tb_cnt_scheduler;

  localparam int BW = 8;
  localparam int NR = 4;
  localparam int IW = 2;

  logic            I_CLK;
  logic            I_RSTN;
  logic [NR-1:0]   i_req;
  logic [NR*BW-1:0] i_max_cnt;
  logic            i_hold;
  logic            i_abort;
  logic [NR-1:0]   o_grant;
  logic [IW-1:0]   o_owner;
  logic            o_busy;
  logic [BW-1:0]   o_cnt;
  logic [NR-1:0]   o_done;

  cnt_scheduler #(.BIT_WIDTH(BW), .NUM_REQ(NR)) dut (
    .I_CLK     (I_CLK),
    .I_RSTN    (I_RSTN),
    .i_req     (i_req),
    .i_max_cnt (i_max_cnt),
    .i_hold    (i_hold),
    .i_abort   (i_abort),
    .o_grant   (o_grant),
    .o_owner   (o_owner),
    .o_busy    (o_busy),
    .o_cnt     (o_cnt),
    .o_done    (o_done)
  );

  // Clock / reset
  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  // Scoreboard state
  int n_checks = 0;
  int n_fail   = 0;
  logic [NR-1:0] exp_q[$];

  // Reference model: an interval is (owner, terminal, count) or idle.
  int m_busy, m_owner, m_term, m_cnt, m_ptr;

  // Observation statistics for directed scenarios
  int busy_cycles, done_seen, prev_busy;
  int obs_owner_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic clear_stats();
    busy_cycles = 0;
    done_seen   = 0;
    obs_owner_q.delete();
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_term = 0; m_cnt = 0; m_ptr = 0;
    prev_busy = 0;
    exp_q.delete();
  endtask

  task automatic model_advance();
    int found;
    int c;
    if (m_busy == 0) begin
      if (i_req != '0) begin
        found = 0;
        for (int i = 0; i < NR; i++) begin
          c = (m_ptr + i) % NR;
          if (found == 0 && i_req[c]) begin
            found   = 1;
            m_owner = c;
          end
        end
        m_term = int'((i_max_cnt >> (m_owner * BW)) & 32'hFF);
        m_cnt  = 0;
        m_busy = 1;
      end
    end else if (i_abort) begin
      m_busy = 0; m_cnt = 0; m_ptr = (m_owner + 1) % NR;
    end else if (!i_hold && m_cnt == m_term) begin
      m_busy = 0; m_cnt = 0; m_ptr = (m_owner + 1) % NR;
    end else if (!i_hold) begin
      m_cnt = m_cnt + 1;
    end
  endtask

  // One clock: compare at negedge, advance model, return at posedge+1.
  task automatic step();
    logic [NR-1:0] e_grant, e_done;
    logic [NR-1:0] sb;
    @(negedge I_CLK);
    e_grant = (m_busy != 0) ? (NR'(1) << m_owner) : '0;
    e_done  = (m_busy != 0 && !i_abort && !i_hold && m_cnt == m_term) ? (NR'(1) << m_owner) : '0;
    check("grant", 32'(o_grant), 32'(e_grant));
    check("owner", 32'(o_owner), (m_busy != 0) ? 32'(m_owner) : 32'd0);
    check("busy",  32'(o_busy),  32'(m_busy));
    check("cnt",   32'(o_cnt),   32'(m_cnt));
    check("done",  32'(o_done),  32'(e_done));
    if (e_done != '0) exp_q.push_back(e_done);
    if (o_done != '0) begin
      if (exp_q.size() == 0) check("done_spurious", 32'(o_done), 32'd0);
      else begin
        sb = exp_q.pop_front();
        check("done_sb", 32'(o_done), 32'(sb));
      end
      done_seen++;
    end
    if (o_busy) busy_cycles++;
    if (o_busy && prev_busy == 0) obs_owner_q.push_back(int'(o_owner));
    prev_busy = int'(o_busy);
    model_advance();
    @(posedge I_CLK);
    #1;
  endtask

  task automatic set_slice(input int k, input int v);
    logic [31:0] vv;
    vv = 32'(v);
    i_max_cnt[k*BW +: BW] = vv[BW-1:0];
  endtask

  task automatic wait_cnt(input int target, input int budget);
    int n;
    n = 0;
    while (!(m_busy != 0 && m_cnt == target) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check("wait_cnt_timeout", 32'(n), 32'(budget - 1));
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while (m_busy != 0 && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check("run_idle_timeout", 32'(n), 32'(budget - 1));
    step();
  endtask

  task automatic check_owners(input string tag, input int exp_own[$]);
    check({tag, "_n"}, 32'(obs_owner_q.size()), 32'(exp_own.size()));
    for (int i = 0; i < exp_own.size() && i < obs_owner_q.size(); i++) begin
      check(tag, 32'(obs_owner_q[i]), 32'(exp_own[i]));
    end
  endtask

  initial begin
    int own_q[$];
    I_RSTN = 1'b0; i_req = '0; i_max_cnt = '0; i_hold = 1'b0; i_abort = 1'b0;
    model_reset();
    clear_stats();
    #1;
    check("rst_grant", 32'(o_grant), 32'd0);
    check("rst_busy",  32'(o_busy),  32'd0);
    check("rst_cnt",   32'(o_cnt),   32'd0);
    check("rst_done",  32'(o_done),  32'd0);
    check("rst_owner", 32'(o_owner), 32'd0);
    @(posedge I_CLK); @(posedge I_CLK); #3;
    I_RSTN = 1'b1;

    // Round-robin fairness: terminals 0, all requesting
    clear_stats();
    i_req = 4'b1111;
    for (int i = 0; i < 10; i++) step();
    i_req = '0;
    step();
    own_q = '{0, 1, 2, 3, 0};
    check_owners("rr_order", own_q);
    check("rr_dones", 32'(done_seen), 32'd5);

    // Single request, terminal 3
    clear_stats();
    set_slice(1, 3);
    i_req = 4'b0010;
    step();
    i_req = '0;
    run_idle(20);
    check("single_len",  32'(busy_cycles), 32'd4);
    check("single_done", 32'(done_seen),   32'd1);
    own_q = '{1};
    check_owners("single_owner", own_q);

    // Hold for two cycles at cnt=1, terminal changed mid-run
    clear_stats();
    set_slice(0, 2);
    i_req = 4'b0001;
    step();
    i_req = '0;
    step();
    i_hold = 1'b1; set_slice(0, 9);
    step(); step();
    i_hold = 1'b0;
    step(); step(); step();
    check("hold_len",  32'(busy_cycles), 32'd5);
    check("hold_done", 32'(done_seen),   32'd1);

    // Abort at cnt=4 with requester 3 pending
    clear_stats();
    set_slice(2, 10); set_slice(3, 1);
    i_req = 4'b1100;
    step();
    i_req = 4'b1000;
    wait_cnt(4, 20);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    check("abort_busy_next", 32'(o_busy), 32'd0);
    step();
    i_req = '0;
    run_idle(20);
    own_q = '{2, 3};
    check_owners("abort_owner", own_q);
    check("abort_dones", 32'(done_seen), 32'd1);

    // Abort in the completion cycle: no done, pointer still moves past owner
    clear_stats();
    set_slice(1, 3);
    i_req = 4'b0010;
    step();
    i_req = '0;
    wait_cnt(3, 20);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    check("avc_done", 32'(done_seen), 32'd0);
    set_slice(0, 0);
    i_req = 4'b0011;
    step();
    i_req = '0;
    run_idle(20);
    own_q = '{1, 0};
    check_owners("avc_ptr", own_q);

    // Maximum terminal count
    clear_stats();
    set_slice(0, 255);
    i_req = 4'b0001;
    step();
    i_req = '0;
    run_idle(300);
    check("max_len",  32'(busy_cycles), 32'd256);
    check("max_done", 32'(done_seen),   32'd1);

    // Randomized traffic
    for (int k = 0; k < NR; k++) set_slice(k, $urandom_range(0, 5));
    for (int n = 0; n < 2000; n++) begin
      i_req   = ($urandom_range(0, 3) == 0) ? '0 : NR'($urandom_range(0, 15));
      i_hold  = ($urandom_range(0, 4) == 0);
      i_abort = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 15) == 0) set_slice($urandom_range(0, NR-1), $urandom_range(0, 6));
      step();
    end
    i_req = '0; i_hold = 1'b0; i_abort = 1'b0;
    run_idle(50);

    // Asynchronous reset mid-run
    set_slice(2, 10);
    i_req = 4'b0100;
    step();
    i_req = '0;
    wait_cnt(5, 20);
    #2;
    I_RSTN = 1'b0;
    #1;
    check("arst_grant", 32'(o_grant), 32'd0);
    check("arst_busy",  32'(o_busy),  32'd0);
    check("arst_cnt",   32'(o_cnt),   32'd0);
    check("arst_done",  32'(o_done),  32'd0);
    check("arst_owner", 32'(o_owner), 32'd0);
    model_reset();
    @(posedge I_CLK); @(posedge I_CLK); #3;
    I_RSTN = 1'b1;
    clear_stats();
    set_slice(0, 1); set_slice(3, 1);
    i_req = 4'b1001;
    step(); step();
    i_req = '0;
    run_idle(20);
    check("arst_first_n", 32'(obs_owner_q.size()), 32'd1);
    if (obs_owner_q.size() > 0) check("arst_first_owner", 32'(obs_owner_q[0]), 32'd0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cnt_scheduler.md
# cnt_scheduler

Round-robin scheduler that shares a single programmable interval counter among NUM_REQ requesters. Each requester raises a level request; the scheduler grants the counter to one requester at a time, loads that requester's terminal count, runs the count, and pulses a per-requester done when the interval completes. It sits between the requesting timing/control blocks and the shared counting resource. It contains its own count register, so no external counter instance is needed.

## Interface
- BIT_WIDTH, 8, width of the count and of each terminal-count field
- NUM_REQ, 4, number of requesters (2..16)
- IDX_W, $clog2(NUM_REQ), width of the owner index
- I_CLK  input  1  clock, rising edge
- I_RSTN  input  1  asynchronous, active-low reset
- i_req  input  NUM_REQ  level request per requester
- i_max_cnt  input  NUM_REQ*BIT_WIDTH  terminal count per requester; requester k uses bits [k*BIT_WIDTH +: BIT_WIDTH]
- i_hold  input  1  freezes the running count while high
- i_abort  input  1  terminates the current interval without done
- o_grant  output  NUM_REQ  one-hot owner of the counter, all-zero when idle
- o_owner  output  IDX_W  index of the current owner, 0 when idle
- o_busy  output  1  high while an interval is running
- o_cnt  output  BIT_WIDTH  current count value
- o_done  output  NUM_REQ  one-hot, one-cycle completion pulse to the owner

## Operation
- Reset: state IDLE; count, latched terminal, and RR pointer all 0. All outputs 0.
- States: IDLE and RUN.
- IDLE:
  - If any i_req bit is set, pick the winner by round-robin. Search starts at pointer index and increases modulo NUM_REQ; the first set bit wins.
  - Latch the winner index and that requester's i_max_cnt slice. Clear the count. Go to RUN.
  - With no request, stay in IDLE.
- RUN:
  - o_grant = one-hot(owner), o_owner = owner, o_busy = 1.
  - Each cycle, in priority order:
    - i_abort: go to IDLE; count clears; no done; pointer = owner+1 mod NUM_REQ.
    - count == latched terminal and i_hold low: o_done[owner] = 1 this cycle; go to IDLE; count clears; pointer = owner+1 mod NUM_REQ.
    - i_hold low: count increments by 1.
    - i_hold high: count holds; o_done suppressed.
- The terminal count is sampled only at grant. Later changes to i_max_cnt do not affect the running interval.
- Deasserting i_req during RUN does not cancel the interval; the grant is committed.
- i_abort and completion in the same cycle: abort wins; no done.
- i_abort in IDLE is ignored and does not block arbitration that cycle.
- Terminal 0: RUN lasts exactly 1 cycle, with done in that cycle (if i_hold is low).
- Terminal 2^BIT_WIDTH-1: the count reaches all-ones without wrapping.
- Count width is BIT_WIDTH, unsigned; no overflow is possible because the terminal is at most all-ones.
- A requester that holds i_req high after done is re-granted only after the other pending requesters have been served.

## Timing
- i_req seen in IDLE at cycle t -> o_grant/o_busy high from cycle t+1, with o_cnt = 0.
- With i_hold low throughout, o_done pulses in cycle t+1+M (M = terminal count); o_grant lasts M+1 cycles.
- o_grant, o_busy, o_owner, o_cnt return to 0 in cycle t+2+M.
- At least one IDLE cycle separates consecutive grants; back-to-back throughput is one interval per M+2 cycles.
- Each held cycle extends the interval by one cycle.
- o_done is decoded from registered state/count only, with no input-to-output path except via i_hold and i_abort.
- Asynchronous reset mid-RUN: all outputs go to 0 immediately; no done is issued; pointer returns to 0.

## Test plan
- Single request: i_req=4'b0010, slice1=3, hold/abort low -> grant 4'b0010 for 4 cycles, o_cnt 0,1,2,3, o_done=4'b0010 in the cnt=3 cycle, idle next cycle.
- Round-robin fairness: i_req=4'b1111 held, all terminals=0 -> grants 0,1,2,3,0 on alternate cycles, each with a done pulse.
- Hold and latch: slice0=2, i_hold high for 2 cycles at cnt=1, i_max_cnt changed to 9 mid-run -> done at cnt=2, 5 grant cycles total.
- Abort: slice2=10, i_abort at cnt=4 -> no done; IDLE next cycle; a pending i_req[3] is granted after one idle cycle.
- Abort vs completion: i_abort asserted in the cnt==terminal cycle -> o_done stays 0; pointer still advances.
- Reset mid-run: I_RSTN low at cnt=5 -> all outputs 0 asynchronously; after release, i_req=4'b1001 grants requester 0 first.
